// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite master driven by a local command interface
//
// Purpose: accepts one read or write command at a time on the cmd_* port,
// runs the matching AXI4-Lite channel handshakes and reports completion on
// the rsp_* port as a one-cycle rsp_valid pulse.
//
// Ports:
//   ACLK, ARESETN              clock and asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_write/addr/wdata/wstrb command payload, captured on acceptance
//   rsp_valid                  one-cycle completion pulse
//   rsp_write/rdata/resp       completion payload, held until the next completion
//   M_AXI_AW*/W*/B*            AXI4-Lite write address, data and response channels
//   M_AXI_AR*/R*               AXI4-Lite read address and data channels

module axi4_lite_master #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,

    output logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,

    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,

    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,

    output logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,

    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RDATA
    } state_t;

    state_t                     state_q;

    // Holding registers: the AXI side is driven only from these.
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [STRB_WIDTH-1:0]      wstrb_q;
    logic                       write_q;

    logic                       awvalid_q;
    logic                       wvalid_q;
    logic                       bready_q;
    logic                       arvalid_q;
    logic                       rready_q;

    // AW and W may complete in different cycles; remember which is finished.
    logic                       aw_done_q;
    logic                       w_done_q;

    logic                       rsp_valid_q;
    logic                       rsp_write_q;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q;
    logic [1:0]                 rsp_resp_q;

    logic                       aw_hs;
    logic                       w_hs;
    logic                       aw_done_d;
    logic                       w_done_d;
    logic                       cmd_accept;

    assign aw_hs      = awvalid_q & M_AXI_AWREADY;
    assign w_hs       = wvalid_q  & M_AXI_WREADY;
    assign aw_done_d  = aw_done_q | aw_hs;
    assign w_done_d   = w_done_q  | w_hs;
    assign cmd_accept = (state_q == S_IDLE) & cmd_valid;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            // Completion pulse lasts exactly one cycle unless re-armed below.
            rsp_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (cmd_accept) begin
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        write_q   <= cmd_write;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WRITE;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_READ;
                        end
                    end
                end

                S_WRITE: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                    end
                    // Both channels finished, possibly on this very edge.
                    if (aw_done_d && w_done_d) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= S_WRESP;
                    end else begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                    end
                end

                S_WRESP: begin
                    if (M_AXI_BVALID && bready_q) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= write_q;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= M_AXI_BRESP;
                        state_q     <= S_IDLE;
                    end
                end

                S_READ: begin
                    if (arvalid_q && M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RDATA;
                    end
                end

                S_RDATA: begin
                    if (M_AXI_RVALID && rready_q) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= write_q;
                        rsp_rdata_q <= M_AXI_RDATA;
                        rsp_resp_q  <= M_AXI_RRESP;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);

    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;

    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;

    assign M_AXI_BREADY  = bready_q;

    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;

    assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

Single-outstanding AXI4-Lite master sitting directly upstream of `axi4_lite_slave`. Converts a simple local command interface (one read or write per command) into AXI4-Lite channel handshakes and returns the read data and response code to the local requester as a one-cycle pulse. Only one transaction is in flight at a time; a new command is accepted only once the previous one has completed.

## Interface
- `ADDRESS_WIDTH`, 32, AXI and command address width
- `DATA_WIDTH`, 32, data width; must be 32 or 64
- `ACLK` in 1: clock, all logic on rising edge
- `ARESETN` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command request
- `cmd_ready` out 1: high only in IDLE; a command is accepted when `cmd_valid && cmd_ready`
- `cmd_write` in 1: 1 = write, 0 = read
- `cmd_addr` in ADDRESS_WIDTH: transaction address
- `cmd_wdata` in DATA_WIDTH: write data
- `cmd_wstrb` in DATA_WIDTH/8: write byte strobes
- `rsp_valid` out 1: one-cycle completion pulse
- `rsp_write` out 1: completed transaction was a write
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes
- `rsp_resp` out 2: BRESP or RRESP of the completed transaction
- `M_AXI_AWADDR` out ADDRESS_WIDTH, `M_AXI_AWPROT` out 3 (constant 3'b000), `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1
- `M_AXI_WDATA` out DATA_WIDTH, `M_AXI_WSTRB` out DATA_WIDTH/8, `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1
- `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1
- `M_AXI_ARADDR` out ADDRESS_WIDTH, `M_AXI_ARPROT` out 3 (constant 3'b000), `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1
- `M_AXI_RDATA` in DATA_WIDTH, `M_AXI_RRESP` in 2, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1

## Operation
- **Reset:**
  - FSM goes to IDLE.
  - All AXI valid/ready outputs are 0; addresses, data, strobes and `rsp_*` outputs are 0.
  - `cmd_ready` is 1 once reset is deasserted.
- **Command capture:** on acceptance, register addr, wdata, wstrb and write into holding registers. AXI outputs drive only from these registers, never from `cmd_*` directly.
- **FSM states:** IDLE, WRITE, WRESP, READ, RDATA.
- **IDLE:**
  - On accept with `cmd_write`=1, go to WRITE and set AWVALID = WVALID = 1.
  - On accept with `cmd_write`=0, go to READ and set ARVALID = 1.
- **WRITE:**
  - AW and W complete independently. Each VALID drops on the cycle after its own handshake (VALID && READY at a clock edge) and is tracked by a done flag.
  - When both are done (including both in the same cycle), go to WRESP and set BREADY = 1.
  - A VALID, once raised, stays high and its payload stays stable until handshake.
- **WRESP:**
  - On BVALID && BREADY, capture BRESP, clear BREADY, pulse `rsp_valid` with `rsp_write`=1 and `rsp_rdata`=0, and return to IDLE.
- **READ:**
  - On ARVALID && ARREADY, clear ARVALID, go to RDATA and set RREADY = 1.
- **RDATA:**
  - On RVALID && RREADY, capture RDATA and RRESP, clear RREADY, pulse `rsp_valid` with `rsp_write`=0, and return to IDLE.
- **Response outputs:** `rsp_rdata`, `rsp_resp` and `rsp_write` hold their values until the next completion. `rsp_valid` is high for exactly one cycle.
- **Error responses:** SLVERR and DECERR are passed through unchanged; the block does not retry.
- **Ignored inputs:**
  - `cmd_*` is ignored outside IDLE.
  - Unsolicited BVALID/RVALID outside WRESP/RDATA is ignored (the matching READY is 0).
- **Reset mid-transaction:** all VALID/READY outputs drop immediately (asynchronous reset), and the transaction is lost with no `rsp_valid`.

## Timing
- Cycle 0 is the command acceptance edge; AWVALID/WVALID/ARVALID are high from cycle 1.
- **Zero-wait-state slave:**
  - Write: AW/W handshake at edge 1, BREADY high in cycle 2, B handshake at edge 2, `rsp_valid` high in cycle 3.
  - Read: same shape; `rsp_valid` high in cycle 3.
- `cmd_ready` returns high in the same cycle as `rsp_valid`, so back-to-back commands are accepted every 3 cycles minimum.
- Each wait state on any slave ready/valid input adds exactly one cycle.
- There is no timeout; a non-responding slave stalls the FSM indefinitely.

## Test plan
- **Zero-wait write:** write addr 0x4, data 0xDEADBEEF, strb 0xF, slave ready/valid always 1 → AW/W valid cycle 1, `rsp_valid` cycle 3, `rsp_resp`=0, `rsp_write`=1.
- **Read back:** read addr 0x4, slave returns RDATA 0xDEADBEEF, RRESP=0 → `rsp_rdata`=0xDEADBEEF in cycle 3; ARADDR is 0x4 for the whole ARVALID window.
- **Skewed write ready:** AWREADY at cycle 1, WREADY delayed to cycle 4 → AWVALID low from cycle 2, WVALID held with stable WDATA until the cycle-4 handshake, BREADY high cycle 5, `rsp_valid` the cycle after the B handshake.
- **Error and backpressure:** RVALID delayed 5 cycles with RRESP=2'b10 → RREADY held high throughout, `rsp_resp`=2'b10, exactly one `rsp_valid` pulse; `cmd_valid` asserted during the transaction is not accepted.
- **Reset mid-transaction:** ARESETN asserted while in WRESP with BREADY=1 → BREADY and all VALIDs 0 immediately, no `rsp_valid`; after release `cmd_ready`=1 and a new write completes normally.
- **Back-to-back:** cmd_valid held high with write-then-read commands → second command accepted in the cycle of the first `rsp_valid`; `rsp_write` sequence is 1 then 0.
